// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned HILO_W = 64;

  typedef enum logic [2:0] {
    MduNone  = 3'd0,
    MduMult  = 3'd1,
    MduMultu = 3'd2,
    MduDiv   = 3'd3,
    MduDivu  = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } mdu_state_t;

endpackage

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider on unsigned operands, one quotient bit per cycle.
// quot/rem carry the value of the current step, so they are final in the cycle done is high.
module div_radix2
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);

  logic              busy_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvsr_q;
  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quot_step;

  // Trial subtraction; a borrow restores the shifted remainder and yields a 0 quotient bit.
  always_comb begin
    trial = {rem_q, quot_q[DATA_W-1]} - {1'b0, dvsr_q};
    if (trial[DATA_W]) begin
      rem_step = {rem_q[DATA_W-2:0], quot_q[DATA_W-1]};
    end else begin
      rem_step = trial[DATA_W-1:0];
    end
    quot_step = {quot_q[DATA_W-2:0], ~trial[DATA_W]};
  end

  assign done = busy_q & (cnt_q == CntW'(DIV_ITERS - 1));
  assign quot = quot_step;
  assign rem  = rem_step;

  // Dividend shifts out of quot_q as quotient bits shift in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else if (flush) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quot_q <= a;
      rem_q  <= '0;
      dvsr_q <= b;
    end else if (busy_q) begin
      quot_q <= quot_step;
      rem_q  <= rem_step;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit producing {HI,LO} for MULT/MULTU/DIV/DIVU.
// Multiply completes in 2 cycles, divide in 33; stall_o holds the front end while busy.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                e_valid_i,
  input  mdu_op_t             e_op_i,
  input  logic [DATA_W-1:0]   src_a_i,
  input  logic [DATA_W-1:0]   src_b_i,
  input  logic                flush_i,
  input  logic                stall_ext_i,
  output logic                stall_o,
  output logic                result_vld_o,
  output logic [2*DATA_W-1:0] hilo_o
);

  localparam int unsigned HW = 2 * DATA_W;

  mdu_state_t        state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              sgn_q;
  logic              q_neg_q;
  logic              r_neg_q;
  logic [HW-1:0]     hilo_q;

  logic              start;
  logic              is_div;
  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [HW-1:0]     ext_a;
  logic [HW-1:0]     ext_b;
  logic [HW-1:0]     prod;
  logic              div_done;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rem;
  logic [DATA_W-1:0] lo_fix;
  logic [DATA_W-1:0] hi_fix;

  // Op decode, operand magnitudes and sign fixup of the divider result.
  always_comb begin
    start     = (state_q == StIdle) & e_valid_i & (e_op_i != MduNone) & ~flush_i;
    is_div    = (e_op_i == MduDiv) | (e_op_i == MduDivu);
    is_signed = (e_op_i == MduMult) | (e_op_i == MduDiv);
    a_neg     = is_signed & src_a_i[DATA_W-1];
    b_neg     = is_signed & src_b_i[DATA_W-1];
    abs_a     = a_neg ? -src_a_i : src_a_i;
    abs_b     = b_neg ? -src_b_i : src_b_i;
    // Low HW bits of the product are the same for signed and unsigned once sign-extended.
    ext_a     = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
    ext_b     = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
    prod      = ext_a * ext_b;
    lo_fix    = q_neg_q ? -div_quot : div_quot;
    hi_fix    = r_neg_q ? -div_rem : div_rem;
  end

  div_radix2 #(
    .DATA_W   (DATA_W),
    .DIV_ITERS(DIV_ITERS)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(start & is_div),
    .a    (abs_a),
    .b    (abs_b),
    .flush(flush_i),
    .done (div_done),
    .quot (div_quot),
    .rem  (div_rem)
  );

  // Control FSM; also latches operands and registers the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hilo_q  <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= src_a_i;
            b_q     <= src_b_i;
            sgn_q   <= is_signed;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            state_q <= is_div ? StDiv : StMul;
          end
        end
        StMul: begin
          hilo_q  <= prod;
          state_q <= StDone;
        end
        StDiv: begin
          if (div_done) begin
            hilo_q  <= {hi_fix, lo_fix};
            state_q <= StDone;
          end
        end
        StDone: begin
          // Leaving DONE never restarts on the op still shown on e_op_i.
          if (!stall_ext_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o      = (start | (state_q == StMul) | (state_q == StDiv)) & ~flush_i;
  assign result_vld_o = (state_q == StDone) & ~flush_i;
  assign hilo_o       = hilo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corners plus randomized ops against a
// plain-arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              e_valid = 1'b0;
  mdu_op_t           e_op = MduNone;
  logic [31:0]       src_a = '0;
  logic [31:0]       src_b = '0;
  logic              flush = 1'b0;
  logic              stall_ext = 1'b0;
  logic              stall;
  logic              result_vld;
  logic [HILO_W-1:0] hilo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(
    .DATA_W   (32),
    .DIV_ITERS(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .e_valid_i   (e_valid),
    .e_op_i      (e_op),
    .src_a_i     (src_a),
    .src_b_i     (src_b),
    .flush_i     (flush),
    .stall_ext_i (stall_ext),
    .stall_o     (stall),
    .result_vld_o(result_vld),
    .hilo_o      (hilo)
  );

  // Reference: MIPS HI/LO semantics from integer arithmetic.
  function automatic logic [63:0] model(input mdu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MduMult:  return sa * sb;
      MduMultu: return ua * ub;
      MduDivu: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MduDiv: begin
        // Raw quotient all-ones, remainder |a|, then the usual sign fixup.
        if (b == 0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Issue one op, hold it in E until DONE, then retire it. Reports latency from the start
  // cycle, number of stall cycles, the result and whether anything odd followed.
  task automatic do_op(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output logic [63:0] res,
                       output logic extra);
    lat    = -1;
    stalls = 0;
    res    = '0;
    extra  = 1'b0;
    @(negedge clk);
    e_valid = 1'b1;
    e_op    = op;
    src_a   = a;
    src_b   = b;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (result_vld) begin
        lat   = c;
        res   = hilo;
        extra = stall;
        break;
      end
      if (stall) stalls++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    e_valid = 1'b0;
    e_op    = MduNone;
    src_a   = $urandom;
    src_b   = $urandom;
    #1;
    if (result_vld || stall) extra = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++;
    if (result_vld !== 1'b0) begin
      errors++; $display("FAIL reset_vld got %b exp 0", result_vld);
    end
    checks++;
    if (hilo !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h exp 0", hilo); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mult_directed();
    int          lat;
    int          st;
    logic [63:0] res;
    logic        ex;
    do_op(MduMult, 32'hFFFF_FFFD, 32'd7, lat, st, res, ex);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL mult_lat got %0d exp 2", lat); end
    checks++;
    if (st !== 2) begin errors++; $display("FAIL mult_stall_cycles got %0d exp 2", st); end
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++; $display("FAIL mult_neg got %h exp %h", res, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    checks++;
    if (ex !== 1'b0) begin errors++; $display("FAIL mult_retire got %b exp 0", ex); end
    do_op(MduMultu, 32'hFFFF_FFFF, 32'd2, lat, st, res, ex);
    checks++;
    if (res !== 64'h0000_0001_FFFF_FFFE || lat !== 2) begin
      errors++;
      $display("FAIL multu got %h lat %0d exp %h lat 2", res, lat, 64'h0000_0001_FFFF_FFFE);
    end
  endtask

  task automatic test_mult_random();
    int          lat;
    int          st;
    logic [63:0] res;
    logic [63:0] exp_res;
    logic        ex;
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? MduMult : MduMultu;
      a  = $urandom;
      b  = $urandom;
      if (i == 0) a = 32'h8000_0000;
      if (i == 1) b = 32'h0;
      exp_res = model(op, a, b);
      do_op(op, a, b, lat, st, res, ex);
      checks++;
      if (res !== exp_res || lat !== 2 || ex !== 1'b0) begin
        errors++;
        $display("FAIL mult_rand op %0d a %h b %h got %h lat %0d exp %h lat 2",
                 op, a, b, res, lat, exp_res);
      end
    end
  endtask

  task automatic test_div_directed();
    int          lat;
    int          st;
    logic [63:0] res;
    logic        ex;
    do_op(MduDiv, 32'hFFFF_FFF9, 32'd2, lat, st, res, ex);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL div_lat got %0d exp 33", lat); end
    checks++;
    if (st !== 33) begin errors++; $display("FAIL div_stall_cycles got %0d exp 33", st); end
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++; $display("FAIL div_neg got %h exp %h", res, 64'hFFFF_FFFF_FFFF_FFFD);
    end
    checks++;
    if (ex !== 1'b0) begin errors++; $display("FAIL div_retire got %b exp 0", ex); end
    do_op(MduDivu, 32'd100, 32'd0, lat, st, res, ex);
    checks++;
    if (res !== 64'h0000_0064_FFFF_FFFF) begin
      errors++; $display("FAIL divu_by_zero got %h exp %h", res, 64'h0000_0064_FFFF_FFFF);
    end
    do_op(MduDiv, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, res, ex);
    checks++;
    if (res !== 64'h0000_0000_8000_0000) begin
      errors++; $display("FAIL div_overflow got %h exp %h", res, 64'h0000_0000_8000_0000);
    end
    do_op(MduDiv, 32'hFFFF_FF9C, 32'd0, lat, st, res, ex);
    checks++;
    if (res !== model(MduDiv, 32'hFFFF_FF9C, 32'd0)) begin
      errors++;
      $display("FAIL div_neg_by_zero got %h exp %h", res, model(MduDiv, 32'hFFFF_FF9C, 32'd0));
    end
  endtask

  task automatic test_div_random();
    int          lat;
    int          st;
    logic [63:0] res;
    logic [63:0] exp_res;
    logic        ex;
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) == 0) ? MduDiv : MduDivu;
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = -b;
      exp_res = model(op, a, b);
      do_op(op, a, b, lat, st, res, ex);
      checks++;
      if (res !== exp_res || lat !== 33 || ex !== 1'b0) begin
        errors++;
        $display("FAIL div_rand op %0d a %h b %h got %h lat %0d exp %h lat 33",
                 op, a, b, res, lat, exp_res);
      end
    end
  endtask

  task automatic test_flush();
    int          lat;
    int          st;
    logic [63:0] res;
    logic        ex;
    @(negedge clk);
    e_valid = 1'b1;
    e_op    = MduDiv;
    src_a   = 32'd1000;
    src_b   = 32'd7;
    // Cycle T+11 is divide count 10.
    for (int i = 0; i < 11; i++) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got %b exp 1", stall); end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_drop got %b exp 0", stall); end
    @(negedge clk);
    flush   = 1'b0;
    e_valid = 1'b0;
    e_op    = MduNone;
    #1;
    checks++;
    if (stall !== 1'b0 || result_vld !== 1'b0) begin
      errors++; $display("FAIL flush_idle got stall %b vld %b exp 0 0", stall, result_vld);
    end
    do_op(MduMult, 32'd12345, 32'hFFFF_FF00, lat, st, res, ex);
    checks++;
    if (res !== model(MduMult, 32'd12345, 32'hFFFF_FF00) || lat !== 2) begin
      errors++;
      $display("FAIL flush_next_mult got %h lat %0d exp %h lat 2", res, lat,
               model(MduMult, 32'd12345, 32'hFFFF_FF00));
    end
  endtask

  task automatic test_flush_beats_start();
    @(negedge clk);
    e_valid = 1'b1;
    e_op    = MduMult;
    src_a   = 32'd3;
    src_b   = 32'd4;
    flush   = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall got %b exp 0", stall); end
    @(negedge clk);
    flush   = 1'b0;
    e_valid = 1'b0;
    e_op    = MduNone;
    #1;
    checks++;
    if (stall !== 1'b0 || result_vld !== 1'b0) begin
      errors++; $display("FAIL flush_start_idle got stall %b vld %b exp 0 0", stall, result_vld);
    end
  endtask

  task automatic test_stall_ext();
    logic [63:0] exp_res;
    int          held;
    bit          found;
    exp_res = model(MduMultu, 32'hDEAD_BEEF, 32'h1234_5678);
    found   = 1'b0;
    held    = 0;
    @(negedge clk);
    e_valid   = 1'b1;
    e_op      = MduMultu;
    src_a     = 32'hDEAD_BEEF;
    src_b     = 32'h1234_5678;
    stall_ext = 1'b1;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (result_vld) begin found = 1'b1; break; end
      @(negedge clk);
      #1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL stall_ext_done got none exp result"); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL stall_ext_stall got %b exp 0", stall); end
    for (int k = 0; k < 6; k++) begin
      if (result_vld === 1'b1 && hilo === exp_res) held++;
      @(negedge clk);
      if (k == 2) stall_ext = 1'b0;
      if (k == 3) begin e_valid = 1'b0; e_op = MduNone; end
      #1;
    end
    checks++;
    if (held !== 4) begin errors++; $display("FAIL stall_ext_hold got %0d exp 4", held); end
  endtask

  task automatic test_reset_mid_div();
    int          lat;
    int          st;
    logic [63:0] res;
    logic        ex;
    do_op(MduMultu, 32'h0001_0001, 32'h0000_0101, lat, st, res, ex);
    checks++;
    if (res !== 64'h0000_0000_0101_0101) begin
      errors++; $display("FAIL rst_pre_mult got %h exp %h", res, 64'h0000_0000_0101_0101);
    end
    @(negedge clk);
    e_valid = 1'b1;
    e_op    = MduDivu;
    src_a   = 32'd999;
    src_b   = 32'd3;
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst     = 1'b0;
    e_valid = 1'b0;
    e_op    = MduNone;
    #1;
    checks++;
    if (stall !== 1'b0 || result_vld !== 1'b0 || hilo !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_div got stall %b vld %b hilo %h exp 0 0 0", stall, result_vld, hilo);
    end
    @(negedge clk);
    rst = 1'b1;
    do_op(MduDivu, 32'd999, 32'd3, lat, st, res, ex);
    checks++;
    if (res !== 64'h0000_0000_0000_014D || lat !== 33) begin
      errors++;
      $display("FAIL rst_post_div got %h lat %0d exp %h lat 33", res, lat,
               64'h0000_0000_0000_014D);
    end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_mult_random();
    test_div_directed();
    test_div_random();
    test_flush();
    test_flush_beats_start();
    test_stall_ext();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
